mrv32_fetch: RTL and testbench

Fetch stage of the RV32I core; the PC owner on the consuming side of the writeback commit interface. Holds the architectural PC and issues one instruction-memory read per instruction. Presents the fetched word to decode/execute and waits for the commit pulse (instr_accept) together with the next PC (pc_next). Only then does it fetch again, giving blocking one-instruction-in-flight bring-up operation.

---
 rtl/mrv32_fetch_if.sv | 33 +++
 rtl/mrv32_fetch.sv | 108 ++++++++++
 tb/tb_mrv32_fetch.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mrv32_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, decode presentation,
// writeback commit and fault/status reporting.
interface mrv32_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        halt_req;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_accept;
  logic [31:0] pc_next;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [31:0] retire_count;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr_out, pc_out,
           fetch_fault, fault_cause, retire_count,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           halt_req, instr_accept, pc_next
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr_out, pc_out,
           fetch_fault, fault_cause, retire_count,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           halt_req, instr_accept, pc_next
  );
endinterface

// File: rtl/mrv32_fetch.sv
// RV32I fetch stage: owns the PC and keeps exactly one instruction in flight,
// refetching only after writeback commits the next PC.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_REQ   | request at pc presented, waiting for imem_req_ready
// ST_WAIT  | request accepted, waiting for imem response
// ST_HOLD  | instruction presented to decode, waiting for commit
// ST_IDLE  | committed with halt_req set, no fetch until it drops
// ST_FAULT | misaligned pc_next or access error; absorbing until reset
module mrv32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst_n,
  mrv32_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_IDLE,
    ST_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retire_q;
  logic [1:0]  cause_q;
  logic        load_instr;
  logic        load_err;
  logic        commit;
  logic        misaligned;

  assign misaligned = (bus.pc_next[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    load_instr = 1'b0;
    load_err   = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (bus.imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (bus.imem_rsp_err) begin
            load_err = 1'b1;
            state_d  = ST_FAULT;
          end else begin
            load_instr = 1'b1;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.instr_accept) begin
          commit = 1'b1;
          if (misaligned)        state_d = ST_FAULT;
          else if (bus.halt_req) state_d = ST_IDLE;
          else                   state_d = ST_REQ;
        end
      end
      ST_IDLE: begin
        if (!bus.halt_req) state_d = ST_REQ;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      retire_q <= 32'h0;
      cause_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (load_instr) instr_q <= bus.imem_rsp_data;
      if (load_err)   cause_q <= 2'b10;
      // A misaligned target is still loaded so the faulting PC is visible.
      if (commit) begin
        pc_q     <= bus.pc_next;
        retire_q <= retire_q + 32'd1;
        if (misaligned) cause_q <= 2'b01;
      end
    end
  end

  assign bus.imem_req_valid = (state_q == ST_REQ);
  assign bus.imem_addr      = pc_q;
  assign bus.pc_out         = pc_q;
  assign bus.instr_out      = instr_q;
  assign bus.instr_valid    = (state_q == ST_HOLD);
  assign bus.fetch_fault    = (state_q == ST_FAULT);
  assign bus.fault_cause    = cause_q;
  assign bus.retire_count   = retire_q;

endmodule

// File: tb/tb_mrv32_fetch.sv
// Scoreboard bench for mrv32_fetch: directed stimulus pushes expected
// handshakes, instructions and faults; a negedge monitor pops and compares.
module tb_mrv32_fetch;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mrv32_fetch_if bus_if();

  mrv32_fetch #(.RESET_PC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] ret;
  } instr_exp_t;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] pc;
  } fault_exp_t;

  logic [31:0] req_q[$];
  instr_exp_t  instr_q[$];
  fault_exp_t  fault_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_ret = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event with value %h, expected none (t=%0t)", name, act, $time);
  endtask

  // monitor
  logic prev_iv = 1'b0;
  logic prev_ff = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus_if.imem_req_valid && bus_if.imem_req_ready) begin
      if (req_q.size() == 0) unexpected("req_handshake", bus_if.imem_addr);
      else chk("req_addr", bus_if.imem_addr, req_q.pop_front());
    end
    if (bus_if.instr_valid && !prev_iv) begin
      if (instr_q.size() == 0) unexpected("instr_present", bus_if.instr_out);
      else begin
        instr_exp_t e;
        e = instr_q.pop_front();
        chk("instr_out", bus_if.instr_out, e.instr);
        chk("instr_pc", bus_if.pc_out, e.pc);
        chk("instr_retire", bus_if.retire_count, e.ret);
      end
    end
    if (bus_if.fetch_fault && !prev_ff) begin
      if (fault_q.size() == 0) unexpected("fault_rise", {30'h0, bus_if.fault_cause});
      else begin
        fault_exp_t f;
        f = fault_q.pop_front();
        chk("fault_cause", {30'h0, bus_if.fault_cause}, {30'h0, f.cause});
        chk("fault_pc", bus_if.pc_out, f.pc);
      end
    end
    prev_iv <= bus_if.instr_valid;
    prev_ff <= bus_if.fetch_fault;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus_if.imem_req_valid && n < 50) begin
      tick();
      n++;
    end
    chk(name, {31'h0, bus_if.imem_req_valid}, 32'h1);
  endtask

  task automatic fetch(input logic [31:0] data, input int ready_delay,
                       input int rsp_delay, input logic err);
    logic [31:0] a0;
    wait_req("req_seen");
    a0 = bus_if.imem_addr;
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      chk("req_hold_valid", {31'h0, bus_if.imem_req_valid}, 32'h1);
      chk("req_hold_addr", bus_if.imem_addr, a0);
    end
    bus_if.imem_req_ready = 1'b1;
    tick();
    bus_if.imem_req_ready = 1'b0;
    chk("wait_no_req", {31'h0, bus_if.imem_req_valid}, 32'h0);
    for (int i = 1; i < rsp_delay; i++) tick();
    bus_if.imem_rsp_valid = 1'b1;
    bus_if.imem_rsp_data  = data;
    bus_if.imem_rsp_err   = err;
    tick();
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_err   = 1'b0;
  endtask

  task automatic commit(input logic [31:0] nxt, input logic halt);
    int n = 0;
    while (!bus_if.instr_valid && n < 50) begin
      tick();
      n++;
    end
    chk("commit_ready", {31'h0, bus_if.instr_valid}, 32'h1);
    bus_if.pc_next      = nxt;
    bus_if.halt_req     = halt;
    bus_if.instr_accept = 1'b1;
    tick();
    bus_if.instr_accept = 1'b0;
    exp_ret = exp_ret + 32'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_instr_valid", {31'h0, bus_if.instr_valid}, 32'h0);
    chk("rst_instr_out", bus_if.instr_out, 32'h0);
    chk("rst_pc", bus_if.pc_out, RPC);
    chk("rst_retire", bus_if.retire_count, 32'h0);
    chk("rst_fault", {31'h0, bus_if.fetch_fault}, 32'h0);
    chk("rst_cause", {30'h0, bus_if.fault_cause}, 32'h0);
    exp_ret = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.imem_req_ready = 1'b0;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data  = 32'h0;
    bus_if.imem_rsp_err   = 1'b0;
    bus_if.halt_req       = 1'b0;
    bus_if.instr_accept   = 1'b0;
    bus_if.pc_next        = 32'h0;
    tick();
    do_reset();

    // basic fetch/commit at RESET_PC
    chk("first_req_valid", {31'h0, bus_if.imem_req_valid}, 32'h1);
    chk("first_req_addr", bus_if.imem_addr, 32'h100);
    req_q.push_back(32'h100);
    instr_q.push_back('{32'h0000_0013, 32'h100, 32'h0});
    fetch(32'h0000_0013, 0, 2, 1'b0);
    commit(32'h104, 1'b0);
    chk("c1_retire", bus_if.retire_count, exp_ret);
    chk("c1_pc", bus_if.pc_out, 32'h104);
    chk("c1_req_valid", {31'h0, bus_if.imem_req_valid}, 32'h1);
    chk("c1_req_addr", bus_if.imem_addr, 32'h104);

    // stray response and commit while in REQ are ignored
    bus_if.imem_rsp_valid = 1'b1;
    bus_if.imem_rsp_data  = 32'hffff_ffff;
    tick();
    bus_if.imem_rsp_valid = 1'b0;
    chk("stray_rsp_req", {31'h0, bus_if.imem_req_valid}, 32'h1);
    chk("stray_rsp_iv", {31'h0, bus_if.instr_valid}, 32'h0);
    bus_if.instr_accept = 1'b1;
    bus_if.pc_next      = 32'h300;
    tick();
    bus_if.instr_accept = 1'b0;
    chk("stray_acc_retire", bus_if.retire_count, 32'h1);
    chk("stray_acc_pc", bus_if.pc_out, 32'h104);

    // ready back-pressure, then halt at commit
    req_q.push_back(32'h104);
    instr_q.push_back('{32'h0050_0093, 32'h104, 32'h1});
    fetch(32'h0050_0093, 3, 1, 1'b0);
    commit(32'h108, 1'b1);
    chk("halt_retire", bus_if.retire_count, exp_ret);
    for (int i = 0; i < 5; i++) begin
      chk("idle_no_req", {31'h0, bus_if.imem_req_valid}, 32'h0);
      tick();
    end
    bus_if.halt_req = 1'b0;
    chk("idle_release_no_req", {31'h0, bus_if.imem_req_valid}, 32'h0);
    tick();
    chk("resume_req_valid", {31'h0, bus_if.imem_req_valid}, 32'h1);
    chk("resume_req_addr", bus_if.imem_addr, 32'h108);

    // misaligned pc_next
    req_q.push_back(32'h108);
    instr_q.push_back('{32'h0000_0073, 32'h108, 32'h2});
    fault_q.push_back('{2'b01, 32'h202});
    fetch(32'h0000_0073, 0, 1, 1'b0);
    commit(32'h202, 1'b0);
    chk("mis_fault", {31'h0, bus_if.fetch_fault}, 32'h1);
    chk("mis_cause", {30'h0, bus_if.fault_cause}, 32'h1);
    chk("mis_pc", bus_if.pc_out, 32'h202);
    chk("mis_retire", bus_if.retire_count, 32'h3);
    for (int i = 0; i < 2; i++) begin
      bus_if.instr_accept   = 1'b1;
      bus_if.pc_next        = 32'h400;
      bus_if.imem_rsp_valid = 1'b1;
      bus_if.imem_rsp_err   = 1'b1;
      tick();
      bus_if.instr_accept   = 1'b0;
      bus_if.imem_rsp_valid = 1'b0;
      bus_if.imem_rsp_err   = 1'b0;
      tick();
      chk("fault_retire_hold", bus_if.retire_count, 32'h3);
      chk("fault_pc_hold", bus_if.pc_out, 32'h202);
      chk("fault_no_req", {31'h0, bus_if.imem_req_valid}, 32'h0);
      chk("fault_cause_hold", {30'h0, bus_if.fault_cause}, 32'h1);
    end

    // access error
    do_reset();
    req_q.push_back(32'h100);
    fault_q.push_back('{2'b10, 32'h100});
    fetch(32'h0000_0bad, 1, 3, 1'b1);
    chk("err_fault", {31'h0, bus_if.fetch_fault}, 32'h1);
    chk("err_cause", {30'h0, bus_if.fault_cause}, 32'h2);
    chk("err_iv", {31'h0, bus_if.instr_valid}, 32'h0);
    tick();
    chk("err_iv_later", {31'h0, bus_if.instr_valid}, 32'h0);
    chk("err_no_req", {31'h0, bus_if.imem_req_valid}, 32'h0);

    // reset during WAIT with a stale response after release
    do_reset();
    req_q.push_back(32'h100);
    wait_req("r5_req_seen");
    bus_if.imem_req_ready = 1'b1;
    tick();
    bus_if.imem_req_ready = 1'b0;
    chk("r5_in_wait", {31'h0, bus_if.imem_req_valid}, 32'h0);
    tick();
    do_reset();
    tick();
    bus_if.imem_rsp_valid = 1'b1;
    bus_if.imem_rsp_data  = 32'hdead_beef;
    tick();
    bus_if.imem_rsp_valid = 1'b0;
    chk("stale_req_valid", {31'h0, bus_if.imem_req_valid}, 32'h1);
    chk("stale_req_addr", bus_if.imem_addr, 32'h100);
    chk("stale_iv", {31'h0, bus_if.instr_valid}, 32'h0);
    chk("stale_instr_out", bus_if.instr_out, 32'h0);
    chk("stale_retire", bus_if.retire_count, 32'h0);
    req_q.push_back(32'h100);
    instr_q.push_back('{32'h0010_0113, 32'h100, 32'h0});
    fetch(32'h0010_0113, 2, 4, 1'b0);
    commit(32'h104, 1'b0);
    chk("r5_retire", bus_if.retire_count, 32'h1);
    chk("r5_pc", bus_if.pc_out, 32'h104);

    tick();
    tick();
    chk("req_q_drained", req_q.size(), 32'h0);
    chk("instr_q_drained", instr_q.size(), 32'h0);
    chk("fault_q_drained", fault_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
